// File: rtl/cw305_usb_bus_fe.sv
// USB parallel bus front end: turns CW305 host strobes into one-shot register-bank
// read/write transactions and returns read data on the USB data bus.
module cw305_usb_bus_fe #(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pRD_LATENCY   = 2
) (
  input  logic                                   usb_clk,
  input  logic                                   rst,
  input  logic                                   usb_cen_n,
  input  logic                                   usb_rdn,
  input  logic                                   usb_wrn,
  input  logic [pADDR_WIDTH-1:0]                 usb_addr,
  input  logic [7:0]                             usb_din,
  output logic [7:0]                             usb_dout,
  output logic                                   usb_isout,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
  output logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
  output logic [7:0]                             write_data,
  input  logic [7:0]                             read_data,
  output logic                                   reg_write,
  output logic                                   reg_read,
  output logic                                   reg_addrvalid,
  output logic                                   bus_error
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {IDLE, WR_PULSE, RD_REQ, RD_WAIT, RD_HOLD} state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic                     s_cen_n, s_rdn, s_wrn;
  logic                     p_rdn, p_wrn;
  logic [pADDR_WIDTH-1:0]   s_addr;
  logic [7:0]               s_din;
  logic                     latch_addr, latch_din, capture;
  logic                     conflict, wr_fall, rd_fall, rd_abort;

  // Input stage; strobes reset as "already low" so a strobe held through reset needs a fresh edge.
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      s_cen_n <= 1'b1;
      s_rdn   <= 1'b0;
      s_wrn   <= 1'b0;
      p_rdn   <= 1'b0;
      p_wrn   <= 1'b0;
      s_addr  <= '0;
      s_din   <= '0;
    end else begin
      s_cen_n <= usb_cen_n;
      s_rdn   <= usb_rdn;
      s_wrn   <= usb_wrn;
      p_rdn   <= s_rdn;
      p_wrn   <= s_wrn;
      s_addr  <= usb_addr;
      s_din   <= usb_din;
    end
  end

  assign conflict = !s_cen_n && !s_rdn && !s_wrn;
  assign wr_fall  = p_wrn && !s_wrn;
  assign rd_fall  = p_rdn && !s_rdn;
  assign rd_abort = s_rdn || s_cen_n || conflict;

  // State and latency counter register.
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state decode; abort wins over a same-cycle capture.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_addr = 1'b0;
    latch_din  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!s_cen_n && wr_fall && s_rdn) begin
          latch_addr = 1'b1;
          latch_din  = 1'b1;
          state_next = WR_PULSE;
        end else if (!s_cen_n && rd_fall && s_wrn) begin
          latch_addr = 1'b1;
          cnt_next   = CNT_W'(1);
          state_next = RD_REQ;
        end
      end
      WR_PULSE: state_next = IDLE;
      RD_REQ, RD_WAIT: begin
        if (rd_abort) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(pRD_LATENCY)) begin
          capture    = 1'b1;
          state_next = RD_HOLD;
        end else begin
          cnt_next   = cnt + CNT_W'(1);
          state_next = RD_WAIT;
        end
      end
      RD_HOLD: begin
        if (s_rdn || s_cen_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state and latch/capture strobes.
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      usb_dout      <= '0;
      usb_isout     <= 1'b0;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      write_data    <= '0;
      reg_write     <= 1'b0;
      reg_read      <= 1'b0;
      reg_addrvalid <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      reg_write     <= (state_next == WR_PULSE);
      reg_read      <= (state_next == RD_REQ) || (state_next == RD_WAIT);
      reg_addrvalid <= (state_next == WR_PULSE) || (state_next == RD_REQ) ||
                       (state_next == RD_WAIT);
      usb_isout     <= (state_next == RD_HOLD);
      bus_error     <= bus_error || conflict;
      if (capture) usb_dout <= read_data;
      if (latch_addr) begin
        reg_address <= s_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
        reg_bytecnt <= s_addr[pBYTECNT_SIZE-1:0];
      end
      if (latch_din) write_data <= s_din;
    end
  end

endmodule

// File: tb/tb_cw305_usb_bus_fe.sv
// Self-checking bench for cw305_usb_bus_fe: directed bus scenarios followed by
// randomized host traffic, all compared against a cycle-level behavioural model.
module tb_cw305_usb_bus_fe;

  localparam int AW = 21;
  localparam int BW = 7;
  localparam int L  = 2;

  logic          usb_clk, rst;
  logic          usb_cen_n, usb_rdn, usb_wrn;
  logic [AW-1:0] usb_addr;
  logic [7:0]    usb_din, usb_dout, write_data, read_data;
  logic          usb_isout, reg_write, reg_read, reg_addrvalid, bus_error;
  logic [AW-BW-1:0] reg_address;
  logic [BW-1:0]    reg_bytecnt;

  cw305_usb_bus_fe #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW), .pRD_LATENCY(L)) dut (
    .usb_clk(usb_clk), .rst(rst), .usb_cen_n(usb_cen_n), .usb_rdn(usb_rdn),
    .usb_wrn(usb_wrn), .usb_addr(usb_addr), .usb_din(usb_din), .usb_dout(usb_dout),
    .usb_isout(usb_isout), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .write_data(write_data), .read_data(read_data), .reg_write(reg_write),
    .reg_read(reg_read), .reg_addrvalid(reg_addrvalid), .bus_error(bus_error)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  int n_checks, n_fail;
  int wr_pulses, rd_cycles;
  logic isout_seen;

  // Model: what the host should see, plus the bus as the design last sampled it.
  logic [7:0]       m_dout, m_wdata;
  logic [AW-BW-1:0] m_raddr;
  logic [BW-1:0]    m_bcnt;
  logic             m_wr, m_rd, m_av, m_isout, m_err;
  int               m_age;
  logic             ms_cen, ms_rdn, ms_wrn, mp_rdn, mp_wrn;
  logic [AW-1:0]    ms_addr;
  logic [7:0]       ms_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dout = '0; m_wdata = '0; m_raddr = '0; m_bcnt = '0;
    m_wr = 0; m_rd = 0; m_av = 0; m_isout = 0; m_err = 0; m_age = 0;
    ms_cen = 1; ms_rdn = 1; ms_wrn = 1; mp_rdn = 1; mp_wrn = 1;
    ms_addr = '0; ms_din = '0;
  endtask

  // One clock edge of host-visible behaviour, from the bus as sampled one edge earlier.
  task automatic model_edge();
    logic conflict;
    if (rst) begin
      model_reset();
      return;
    end
    conflict = !ms_cen && !ms_rdn && !ms_wrn;
    if (m_wr) begin
      m_wr = 0; m_av = 0;
    end else if (m_rd) begin
      if (ms_rdn || ms_cen || conflict) begin
        m_rd = 0; m_av = 0;
      end else if (m_age == L) begin
        m_dout = read_data; m_isout = 1; m_rd = 0; m_av = 0;
      end else begin
        m_age++;
      end
    end else if (m_isout) begin
      if (ms_rdn || ms_cen) m_isout = 0;
    end else if (!ms_cen) begin
      if (mp_wrn && !ms_wrn && ms_rdn) begin
        m_wr = 1; m_av = 1;
        m_raddr = ms_addr[AW-1:BW]; m_bcnt = ms_addr[BW-1:0]; m_wdata = ms_din;
      end else if (mp_rdn && !ms_rdn && ms_wrn) begin
        m_rd = 1; m_av = 1; m_age = 1;
        m_raddr = ms_addr[AW-1:BW]; m_bcnt = ms_addr[BW-1:0];
      end
    end
    if (conflict) m_err = 1;
    mp_rdn = ms_rdn; mp_wrn = ms_wrn;
    ms_cen = usb_cen_n; ms_rdn = usb_rdn; ms_wrn = usb_wrn;
    ms_addr = usb_addr; ms_din = usb_din;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".usb_dout"},      32'(usb_dout),      32'(m_dout));
    check({tag, ".usb_isout"},     32'(usb_isout),     32'(m_isout));
    check({tag, ".reg_address"},   32'(reg_address),   32'(m_raddr));
    check({tag, ".reg_bytecnt"},   32'(reg_bytecnt),   32'(m_bcnt));
    check({tag, ".write_data"},    32'(write_data),    32'(m_wdata));
    check({tag, ".reg_write"},     32'(reg_write),     32'(m_wr));
    check({tag, ".reg_read"},      32'(reg_read),      32'(m_rd));
    check({tag, ".reg_addrvalid"}, 32'(reg_addrvalid), 32'(m_av));
    check({tag, ".bus_error"},     32'(bus_error),     32'(m_err));
  endtask

  task automatic step(input logic cen, input logic rdn, input logic wrn,
                      input logic [AW-1:0] addr, input logic [7:0] din,
                      input logic [7:0] rdat);
    usb_cen_n = cen; usb_rdn = rdn; usb_wrn = wrn;
    usb_addr = addr; usb_din = din; read_data = rdat;
    @(posedge usb_clk);
    #1;
    model_edge();
    check_all("cyc");
    if (reg_write) wr_pulses++;
    if (reg_read) rd_cycles++;
    if (usb_isout) isout_seen = 1'b1;
  endtask

  initial begin
    logic c, r, w;
    n_checks = 0; n_fail = 0; wr_pulses = 0; rd_cycles = 0; isout_seen = 1'b0;
    rst = 1'b1;
    usb_cen_n = 1'b1; usb_rdn = 1'b1; usb_wrn = 1'b1;
    usb_addr = '0; usb_din = '0; read_data = '0;
    model_reset();
    #1;
    check_all("reset");
    step(1, 1, 1, '0, 8'h00, 8'h00);
    step(1, 1, 1, '0, 8'h00, 8'h00);
    rst = 1'b0;
    repeat (2) step(1, 1, 1, '0, 8'h00, 8'h00);

    // Single write: reg 5, bytecnt 3, data A5, wrn low for 3 cycles.
    wr_pulses = 0; rd_cycles = 0;
    step(0, 1, 1, 21'h00283, 8'hA5, 8'h00);
    repeat (3) step(0, 1, 0, 21'h00283, 8'hA5, 8'h00);
    repeat (3) step(0, 1, 1, 21'h00283, 8'hA5, 8'h00);
    check("wr_pulses", 32'(wr_pulses), 32'd1);
    check("wr_no_read", 32'(rd_cycles), 32'd0);
    check("wr_reg_address", 32'(reg_address), 32'd5);
    check("wr_reg_bytecnt", 32'(reg_bytecnt), 32'd3);
    check("wr_write_data", 32'(write_data), 32'hA5);

    // Single read returning 3C, rdn low for 6 cycles.
    rd_cycles = 0;
    step(0, 1, 1, 21'h00400, 8'h00, 8'h3C);
    repeat (6) step(0, 0, 1, 21'h00400, 8'h00, 8'h3C);
    check("rd_dout", 32'(usb_dout), 32'h3C);
    check("rd_isout_held", 32'(usb_isout), 32'd1);
    step(0, 1, 1, 21'h00400, 8'h00, 8'h3C);
    check("rd_isout_after_rise", 32'(usb_isout), 32'd1);
    step(0, 1, 1, 21'h00400, 8'h00, 8'h3C);
    check("rd_isout_released", 32'(usb_isout), 32'd0);
    check("rd_cycles", 32'(rd_cycles), 32'd2);

    // Four back-to-back writes, bytecnt 0..3.
    wr_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, AW'((6 << BW) | i), 8'(8'h11 * (i + 1)), 8'h00);
      step(0, 1, 1, AW'((6 << BW) | i), 8'(8'h11 * (i + 1)), 8'h00);
    end
    repeat (2) step(0, 1, 1, 21'h00300, 8'h00, 8'h00);
    check("b2b_pulses", 32'(wr_pulses), 32'd4);
    check("b2b_last_data", 32'(write_data), 32'h44);
    check("b2b_last_bytecnt", 32'(reg_bytecnt), 32'd3);
    check("b2b_bus_error", 32'(bus_error), 32'd0);

    // Early release: rdn low one cycle only.
    rd_cycles = 0; isout_seen = 1'b0;
    step(0, 1, 1, 21'h00480, 8'h00, 8'h77);
    step(0, 0, 1, 21'h00480, 8'h00, 8'h77);
    repeat (4) step(0, 1, 1, 21'h00480, 8'h00, 8'h77);
    check("early_rd_cycles", 32'(rd_cycles), 32'd1);
    check("early_isout_never", 32'(isout_seen), 32'd0);
    check("early_dout_kept", 32'(usb_dout), 32'h3C);

    // Both strobes low together.
    wr_pulses = 0; rd_cycles = 0;
    step(0, 1, 1, 21'h00500, 8'h99, 8'h00);
    repeat (3) step(0, 0, 0, 21'h00500, 8'h99, 8'h00);
    repeat (2) step(0, 1, 1, 21'h00500, 8'h99, 8'h00);
    check("conflict_no_write", 32'(wr_pulses), 32'd0);
    check("conflict_no_read", 32'(rd_cycles), 32'd0);
    check("conflict_bus_error", 32'(bus_error), 32'd1);
    step(0, 1, 0, 21'h00581, 8'h66, 8'h00);
    repeat (3) step(0, 1, 1, 21'h00581, 8'h66, 8'h00);
    check("conflict_then_write", 32'(wr_pulses), 32'd1);
    check("conflict_sticky", 32'(bus_error), 32'd1);

    // Reset while waiting on read data, then a clean write.
    rd_cycles = 0;
    step(0, 1, 1, 21'h00600, 8'h00, 8'hE1);
    repeat (3) step(0, 0, 1, 21'h00600, 8'h00, 8'hE1);
    check("rstwait_reg_read", 32'(reg_read), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    check("rst_bus_error", 32'(bus_error), 32'd0);
    step(1, 1, 1, 21'h00600, 8'h00, 8'hE1);
    step(1, 1, 1, 21'h00600, 8'h00, 8'hE1);
    rst = 1'b0;
    wr_pulses = 0; rd_cycles = 0;
    step(1, 1, 1, 21'h00A81, 8'h5A, 8'hE1);
    step(0, 1, 1, 21'h00A81, 8'h5A, 8'hE1);
    step(0, 1, 0, 21'h00A81, 8'h5A, 8'hE1);
    repeat (3) step(0, 1, 1, 21'h00A81, 8'h5A, 8'hE1);
    check("post_rst_pulses", 32'(wr_pulses), 32'd1);
    check("post_rst_no_read", 32'(rd_cycles), 32'd0);
    check("post_rst_address", 32'(reg_address), 32'd21);
    check("post_rst_data", 32'(write_data), 32'h5A);
    check("post_rst_dout", 32'(usb_dout), 32'h00);

    // Random host traffic; conflicts only allowed in the second half.
    c = 1'b0; r = 1'b1; w = 1'b1;
    for (int i = 0; i < 600; i++) begin
      int unsigned pick;
      if ($urandom_range(0, 3) == 0) begin
        pick = $urandom_range(0, (i < 300) ? 3 : 4);
        case (pick)
          0: begin r = 1'b0; w = 1'b1; end
          1: begin r = 1'b1; w = 1'b0; end
          4: begin r = 1'b0; w = 1'b0; end
          default: begin r = 1'b1; w = 1'b1; end
        endcase
        c = ($urandom_range(0, 9) == 0);
      end
      step(c, r, w, AW'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
